// File: rtl/kfps2kb_cmd_pkg.sv
// rtl/kfps2kb_cmd_pkg.sv - shared types and byte constants for the PS/2 host command sequencer
package kfps2kb_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    SEND_ARG,
    WAIT_TX,
    WAIT_ACK,
    WAIT_BAT,
    FINISH_OK,
    FINISH_ERR
  } state_t;

  typedef enum logic {
    REQ_SYS,
    REQ_LED
  } req_src_t;

  localparam logic [7:0] ACK         = 8'hFA;
  localparam logic [7:0] RESEND      = 8'hFE;
  localparam logic [7:0] BAT_OK      = 8'hAA;
  localparam logic [7:0] BAT_FAIL    = 8'hFC;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

endpackage

// File: rtl/kfps2kb_cmd_timer.sv
// rtl/kfps2kb_cmd_timer.sv - loadable down-counter shared by the response and BAT waits
module kfps2kb_cmd_timer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        enable,
  output logic        expire
);

  logic [31:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 32'd0;
    end else if (load) begin
      count <= load_value;
    end else if (clear) begin
      count <= 32'd0;
    end else if (enable && count != 32'd0) begin
      count <= count - 32'd1;
    end
  end

  assign expire = enable && (count == 32'd0);

endmodule

// File: rtl/kfps2kb_cmd_sequencer.sv
// rtl/kfps2kb_cmd_sequencer.sv - sys/LED command arbiter with ACK/RESEND/timeout retry; KFPS2KB_BAT_WAIT_EN adds BAT wait after 0xFF
module kfps2kb_cmd_sequencer
  import kfps2kb_cmd_pkg::*;
#(
  parameter logic [31:0] ack_timeout = 32'd250000,
  parameter int          max_retries = 2,
  parameter logic [31:0] bat_timeout = 32'd25000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sys_req,
  input  logic [7:0] sys_cmd,
  input  logic       sys_has_arg,
  input  logic [7:0] sys_arg,
  output logic       sys_done,
  output logic       sys_err,
  input  logic       led_req,
  input  logic [2:0] led_state,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  input  logic       tx_error,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_consume,
  output logic       busy
);

  localparam logic [7:0] max_retry_cnt = 8'(max_retries);

  state_t     state, next_state;
  req_src_t   req_src;
  logic [7:0] cmd_r, arg_r, retry_cnt;
  logic       has_arg_r, arg_phase, led_pending;
  logic       grant_sys, grant_led, enter_arg, retry_inc, retry_path;
  logic       timer_load, timer_expire;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    tx_start   = 1'b0;
    tx_byte    = 8'h00;
    rx_consume = 1'b0;
    sys_done   = 1'b0;
    sys_err    = 1'b0;
    grant_sys  = 1'b0;
    grant_led  = 1'b0;
    enter_arg  = 1'b0;
    retry_inc  = 1'b0;
    retry_path = 1'b0;
    case (state)
      IDLE: begin
        if (sys_req) begin
          grant_sys  = 1'b1;
          next_state = SEND_CMD;
        end else if (led_pending) begin
          grant_led  = 1'b1;
          next_state = SEND_CMD;
        end
      end
      SEND_CMD: begin
        tx_start   = 1'b1;
        tx_byte    = cmd_r;
        next_state = WAIT_TX;
      end
      SEND_ARG: begin
        tx_start   = 1'b1;
        tx_byte    = arg_r;
        next_state = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_error)     retry_path = 1'b1;
        else if (tx_done) next_state = WAIT_ACK;
      end
      WAIT_ACK: begin
        // A response in the expiry cycle takes precedence over the timeout.
        if (rx_valid && rx_byte == ACK) begin
          rx_consume = 1'b1;
          if (!arg_phase && has_arg_r) begin
            enter_arg  = 1'b1;
            next_state = SEND_ARG;
          end else if (cmd_r == CMD_RESET) begin
`ifdef KFPS2KB_BAT_WAIT_EN
            next_state = WAIT_BAT;
`else
            next_state = FINISH_OK;
`endif
          end else begin
            next_state = FINISH_OK;
          end
        end else if (rx_valid && rx_byte == RESEND) begin
          rx_consume = 1'b1;
          retry_path = 1'b1;
        end else if (timer_expire) begin
          retry_path = 1'b1;
        end
      end
      WAIT_BAT: begin
        if (rx_valid && rx_byte == BAT_OK) begin
          rx_consume = 1'b1;
          next_state = FINISH_OK;
        end else if (rx_valid && rx_byte == BAT_FAIL) begin
          rx_consume = 1'b1;
          next_state = FINISH_ERR;
        end else if (timer_expire) begin
          next_state = FINISH_ERR;
        end
      end
      FINISH_OK: begin
        sys_done   = (req_src == REQ_SYS);
        next_state = IDLE;
      end
      FINISH_ERR: begin
        sys_done   = (req_src == REQ_SYS);
        sys_err    = (req_src == REQ_SYS);
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (retry_path) begin
      if (retry_cnt < max_retry_cnt) begin
        retry_inc  = 1'b1;
        next_state = arg_phase ? SEND_ARG : SEND_CMD;
      end else begin
        next_state = FINISH_ERR;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_src     <= REQ_SYS;
      cmd_r       <= 8'h00;
      arg_r       <= 8'h00;
      has_arg_r   <= 1'b0;
      arg_phase   <= 1'b0;
      retry_cnt   <= 8'd0;
      led_pending <= 1'b0;
    end else begin
      if (grant_sys) begin
        req_src   <= REQ_SYS;
        cmd_r     <= sys_cmd;
        arg_r     <= sys_arg;
        has_arg_r <= sys_has_arg;
        arg_phase <= 1'b0;
        retry_cnt <= 8'd0;
      end else if (grant_led) begin
        req_src   <= REQ_LED;
        cmd_r     <= CMD_SET_LED;
        arg_r     <= {5'b0, led_state};
        has_arg_r <= 1'b1;
        arg_phase <= 1'b0;
        retry_cnt <= 8'd0;
      end else if (enter_arg) begin
        arg_phase <= 1'b1;
        retry_cnt <= 8'd0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + 8'd1;
      end
      // A fresh LED change always wins so the update reissues with the newest state.
      if (led_req)        led_pending <= 1'b1;
      else if (grant_led) led_pending <= 1'b0;
    end
  end

  assign timer_load = (next_state != state) &&
                      (next_state == WAIT_ACK || next_state == WAIT_BAT);

  kfps2kb_cmd_timer u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (state == IDLE),
    .load       (timer_load),
    .load_value ((next_state == WAIT_BAT) ? bat_timeout - 32'd1 : ack_timeout - 32'd1),
    .enable     (state == WAIT_ACK || state == WAIT_BAT),
    .expire     (timer_expire)
  );

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_kfps2kb_cmd_sequencer.sv
// tb/tb_kfps2kb_cmd_sequencer.sv - directed self-checking bench for kfps2kb_cmd_sequencer
module tb_kfps2kb_cmd_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       sys_req, sys_has_arg, led_req, tx_done, tx_error, rx_valid;
  logic [7:0] sys_cmd, sys_arg, rx_byte;
  logic [2:0] led_state;
  logic       sys_done, sys_err, tx_start, rx_consume, busy;
  logic [7:0] tx_byte;

  int n_assert = 0;
  int n_fail   = 0;
  int tx_count = 0;
  int done_count = 0;
  int base, waited;

  always #5 clock = ~clock;

  kfps2kb_cmd_sequencer #(
    .ack_timeout (32'd100),
    .max_retries (2),
    .bat_timeout (32'd300)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sys_req     (sys_req),
    .sys_cmd     (sys_cmd),
    .sys_has_arg (sys_has_arg),
    .sys_arg     (sys_arg),
    .sys_done    (sys_done),
    .sys_err     (sys_err),
    .led_req     (led_req),
    .led_state   (led_state),
    .tx_start    (tx_start),
    .tx_byte     (tx_byte),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .rx_consume  (rx_consume),
    .busy        (busy)
  );

  always @(negedge clock) begin
    if (tx_start) tx_count++;
    if (sys_done) done_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge of the tx_start cycle; waited = negedges stepped.
  task automatic expect_tx(input logic [7:0] exp, input string tag);
    int n = 0;
    while (!tx_start && n < 300) begin
      @(negedge clock);
      n++;
    end
    waited = n;
    chk({tag, "_start"}, {31'b0, tx_start}, 32'd1);
    chk({tag, "_byte"}, {24'b0, tx_byte}, {24'b0, exp});
  endtask

  // Returns at the negedge of the first WAIT_ACK cycle.
  task automatic do_tx_done();
    @(negedge clock);
    tx_done = 1'b1;
    @(negedge clock);
    tx_done = 1'b0;
  endtask

  task automatic respond(input logic [7:0] b, input int delay, input logic consume, input string tag);
    repeat (delay) @(negedge clock);
    rx_valid = 1'b1;
    rx_byte  = b;
    #1;
    chk({tag, "_consume"}, {31'b0, rx_consume}, {31'b0, consume});
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input logic err, input string tag);
    int n = 0;
    while (!sys_done && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_done"}, {31'b0, sys_done}, 32'd1);
    chk({tag, "_err"}, {31'b0, sys_err}, {31'b0, err});
    sys_req = 1'b0;
  endtask

  task automatic start_sys(input logic [7:0] c, input logic ha, input logic [7:0] a);
    sys_cmd = c; sys_has_arg = ha; sys_arg = a; sys_req = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; sys_req = 0; sys_cmd = 0; sys_has_arg = 0; sys_arg = 0;
    led_req = 0; led_state = 0; tx_done = 0; tx_error = 0; rx_valid = 0; rx_byte = 0;
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_tx_start", {31'b0, tx_start}, 32'd0);
    chk("rst_tx_byte", {24'b0, tx_byte}, 32'd0);
    chk("rst_sys_done", {31'b0, sys_done}, 32'd0);
    chk("rst_sys_err", {31'b0, sys_err}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Plain command, ACK 10 cycles after tx_done
    base = tx_count;
    start_sys(8'hF4, 1'b0, 8'h00);
    #1 chk("t1_busy_grant", {31'b0, busy}, 32'd0);
    expect_tx(8'hF4, "t1_cmd");
    chk("t1_busy", {31'b0, busy}, 32'd1);
    do_tx_done();
    respond(8'hFA, 10, 1'b1, "t1_ack");
    wait_done(1'b0, "t1");
    chk("t1_sends", tx_count - base, 32'd1);
    @(negedge clock);
    chk("t1_idle", {31'b0, busy}, 32'd0);

    // LED update
    base = done_count;
    led_state = 3'b101; led_req = 1'b1;
    @(negedge clock);
    led_req = 1'b0;
    expect_tx(8'hED, "t2_cmd");
    do_tx_done();
    respond(8'hFA, 2, 1'b1, "t2_ack1");
    expect_tx(8'h05, "t2_arg");
    do_tx_done();
    respond(8'hFA, 1, 1'b1, "t2_ack2");
    @(negedge clock);
    chk("t2_no_done", done_count - base, 32'd0);
    chk("t2_idle", {31'b0, busy}, 32'd0);

    // Simultaneous sys and LED: sys first, LED resampled afterwards
    start_sys(8'hF4, 1'b0, 8'h00);
    led_state = 3'b001; led_req = 1'b1;
    expect_tx(8'hF4, "t3_sys");
    led_req = 1'b0; led_state = 3'b110;
    do_tx_done();
    respond(8'hFA, 3, 1'b1, "t3_ack");
    wait_done(1'b0, "t3");
    expect_tx(8'hED, "t3_led");
    do_tx_done();
    respond(8'hFA, 1, 1'b1, "t3_ack2");
    expect_tx(8'h06, "t3_arg");
    do_tx_done();
    respond(8'hFA, 1, 1'b1, "t3_ack3");
    @(negedge clock);
    chk("t3_idle", {31'b0, busy}, 32'd0);

    // Two RESENDs then success with argument
    base = tx_count;
    start_sys(8'hF3, 1'b1, 8'h20);
    for (int i = 0; i < 3; i++) begin
      expect_tx(8'hF3, "t4_cmd");
      do_tx_done();
      respond((i < 2) ? 8'hFE : 8'hFA, 2, 1'b1, "t4_rsp");
    end
    expect_tx(8'h20, "t4_arg");
    do_tx_done();
    respond(8'hFA, 2, 1'b1, "t4_ack");
    wait_done(1'b0, "t4");
    chk("t4_sends", tx_count - base, 32'd4);
    @(negedge clock);

    // Three RESENDs exhaust retries
    base = tx_count;
    start_sys(8'hF3, 1'b1, 8'h20);
    for (int i = 0; i < 3; i++) begin
      expect_tx(8'hF3, "t5_cmd");
      do_tx_done();
      respond(8'hFE, 1, 1'b1, "t5_rsp");
    end
    wait_done(1'b1, "t5");
    chk("t5_sends", tx_count - base, 32'd3);
    @(negedge clock);

    // Silent device: timeouts, forwarded scancode, exact retry latency
    base = tx_count;
    start_sys(8'hF5, 1'b0, 8'h00);
    expect_tx(8'hF5, "t6_cmd1");
    do_tx_done();
    respond(8'h1C, 5, 1'b0, "t6_scan");
    expect_tx(8'hF5, "t6_cmd2");
    do_tx_done();
    expect_tx(8'hF5, "t6_cmd3");
    chk("t6_timeout_lat", waited, 32'd100);
    do_tx_done();
    wait_done(1'b1, "t6");
    chk("t6_sends", tx_count - base, 32'd3);
    @(negedge clock);

    // ACK in the final cycle before timeout wins
    base = tx_count;
    start_sys(8'hF4, 1'b0, 8'h00);
    expect_tx(8'hF4, "t7_cmd");
    do_tx_done();
    respond(8'hFA, 99, 1'b1, "t7_ack");
    wait_done(1'b0, "t7");
    chk("t7_sends", tx_count - base, 32'd1);
    @(negedge clock);

    // tx_error together with tx_done forces a resend
    base = tx_count;
    start_sys(8'hF4, 1'b0, 8'h00);
    expect_tx(8'hF4, "t8_cmd1");
    @(negedge clock);
    tx_done = 1'b1; tx_error = 1'b1;
    @(negedge clock);
    tx_done = 1'b0; tx_error = 1'b0;
    expect_tx(8'hF4, "t8_cmd2");
    do_tx_done();
    respond(8'hFA, 1, 1'b1, "t8_ack");
    wait_done(1'b0, "t8");
    chk("t8_sends", tx_count - base, 32'd2);
    @(negedge clock);

    // Reset command
    start_sys(8'hFF, 1'b0, 8'h00);
    expect_tx(8'hFF, "t9_cmd");
    do_tx_done();
    respond(8'hFA, 2, 1'b1, "t9_ack");
`ifdef KFPS2KB_BAT_WAIT_EN
    chk("t9_wait_bat", {31'b0, sys_done}, 32'd0);
    respond(8'hAA, 5, 1'b1, "t9_bat");
    wait_done(1'b0, "t9");
    @(negedge clock);
    start_sys(8'hFF, 1'b0, 8'h00);
    expect_tx(8'hFF, "t9b_cmd");
    do_tx_done();
    respond(8'hFA, 2, 1'b1, "t9b_ack");
    respond(8'hFC, 5, 1'b1, "t9b_bat");
    wait_done(1'b1, "t9b");
`else
    wait_done(1'b0, "t9");
    @(negedge clock);
    respond(8'hAA, 2, 1'b0, "t9_bat_fwd");
`endif
    @(negedge clock);

    // Reset mid-transaction drops the pending LED request
    start_sys(8'hF4, 1'b0, 8'h00);
    expect_tx(8'hF4, "t10_cmd");
    led_req = 1'b1;
    @(negedge clock);
    led_req = 1'b0;
    sys_req = 1'b0;
    reset_n = 1'b0;
    #1 chk("t10_busy_rst", {31'b0, busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    base = tx_count;
    repeat (6) @(negedge clock);
    chk("t10_no_led", tx_count - base, 32'd0);
    chk("t10_idle", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/kfps2kb_cmd_sequencer.md
Name: kfps2kb_cmd_sequencer

Overview:
Host-side command scheduler for the PS/2 keyboard link. It arbitrates between two requesters: the system/CPU command path and the lock-key LED updater. It sequences the external host-to-device byte transmitter and matches device responses (ACK/RESEND/BAT), with retry and timeout. Response bytes are consumed so they never reach the scancode/keycode path.

Parameters:
ack_timeout, 32'd250000, clock cycles to wait for a response after tx_done
max_retries, 2, RESEND (0xFE) retries per byte before error
bat_timeout, 32'd25000000, clock cycles to wait for BAT result after 0xFF ACK

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sys_req  in  1  system command request (level, held until sys_done)
sys_cmd  in  8  command byte
sys_has_arg  in  1  command carries one argument byte
sys_arg  in  8  argument byte
sys_done  out  1  one-cycle pulse: system transaction finished
sys_err  out  1  qualifies sys_done: 1 = failed
led_req  in  1  one-cycle pulse: LED state changed
led_state  in  3  {caps, num, scroll}
tx_start  out  1  one-cycle pulse: transmit tx_byte
tx_byte  out  8  byte to transmit
tx_done  in  1  pulse: byte shifted out, device line-ACK seen
tx_error  in  1  pulse: transmitter framing/no line-ACK
rx_valid  in  1  pulse: byte received from device
rx_byte  in  8  received byte
rx_consume  out  1  combinational, same cycle as rx_valid: byte belongs to a command, suppress forwarding
busy  out  1  transaction in progress

Behaviour:
- Reset (reset_n=0, async): state IDLE; all outputs 0; led_pending=0; retry count 0; timer 0.
- led_req sets led_pending. led_state is sampled at grant into an arg register.
- Arbitration is evaluated only in IDLE, with fixed priority sys > led. In the grant cycle: latch cmd/arg (LED path: cmd 0xED, arg {5'b0,led_state}); clear led_pending (LED path); go to SEND_CMD. busy=1 from the next cycle.
- A led_req arriving during any transaction, including an LED one, re-sets led_pending. The LED command then reissues afterwards with fresh led_state.
- SEND_CMD / SEND_ARG: pulse tx_start for one cycle with tx_byte, then go to WAIT_TX.
- WAIT_TX:
  - tx_done -> WAIT_ACK, timer cleared.
  - tx_error -> retry path.
- WAIT_ACK: timer counts every cycle. On rx_valid, rx_consume=1 and:
  - 0xFA: if the command byte was sent and has_arg, go to SEND_ARG (retry count cleared). Else if cmd==0xFF, go to WAIT_BAT (feature-gated). Else FINISH_OK.
  - 0xFE: retry path, resending the current byte.
  - Any other byte: rx_consume=0 (byte forwarded), stay in WAIT_ACK.
  - Timer reaching ack_timeout-1 with no response: retry path.
- Retry path: if retries < max_retries, increment and resend the same byte; else FINISH_ERR. An ACK on the final cycle before timeout wins over the timeout.
- FINISH_OK / FINISH_ERR: one cycle. For sys: sys_done=1, sys_err=0/1. For LED: no pulse. Return to IDLE; the next grant is possible in the following cycle.
- rx_valid in IDLE: rx_consume=0.
- Simultaneous tx_done and tx_error: tx_error wins.
- sys_req dropped mid-transaction: the transaction completes; sys_done still pulses.
- Reset mid-transaction: immediate return to IDLE; no done pulse; pending LED request lost.

Optional Feature:
KFPS2KB_BAT_WAIT_EN
- Defined: after 0xFF is ACKed, enter WAIT_BAT, timed by bat_timeout.
  - 0xAA -> FINISH_OK.
  - 0xFC -> FINISH_ERR.
  - Timeout -> FINISH_ERR, with no retry.
  - Both result bytes are consumed.
- Undefined: 0xFF completes at ACK, and a later 0xAA is forwarded to the keycode path.

Decomposition:
- Package kfps2kb_cmd_pkg:
  - state enum: IDLE, SEND_CMD, SEND_ARG, WAIT_TX, WAIT_ACK, WAIT_BAT, FINISH_OK, FINISH_ERR.
  - requester enum: REQ_SYS, REQ_LED.
  - byte constants: ACK 0xFA, RESEND 0xFE, BAT_OK 0xAA, BAT_FAIL 0xFC, CMD_SET_LED 0xED, CMD_RESET 0xFF.
- Sub-module kfps2kb_cmd_timer: loadable down-counter with clear, load value and expire pulse, shared by the ACK and BAT waits.

Test Plan:
- sys_cmd=0xF4, has_arg=0; device answers 0xFA 10 cycles after tx_done -> one tx_start(0xF4), rx_consume=1 on the 0xFA, sys_done=1 with sys_err=0.
- led_req with led_state=3'b101 -> tx_byte 0xED, ACK, tx_byte 0x05, ACK; no sys_done; busy low afterwards.
- sys_req and led_req in the same IDLE cycle -> sys command first; after FINISH, LED 0xED sequence starts with led_state resampled.
- cmd 0xF3 arg 0x20; device answers 0xFE twice, then 0xFA, 0xFA -> byte 0xF3 sent 3 times, then 0x20, sys_err=0. Three 0xFE -> 3 sends, then sys_done with sys_err=1.
- No response with ack_timeout=100 -> retries at timeout, sys_err=1 after 3 sends. Device scancode 0x1C arriving during WAIT_ACK -> rx_consume=0.
- cmd 0xFF with KFPS2KB_BAT_WAIT_EN: 0xFA, then 0xAA -> sys_err=0; 0xFC -> sys_err=1. Without the macro: sys_done at 0xFA, and the 0xAA has rx_consume=0.
